// File: rtl/credit_sender.sv
`default_nettype none
// ============================================================================
// Module      : credit_sender
// Description : Transmit end of a credit-based link. Accepts words from a
//               local valid/ready producer and forwards them over a
//               valid-only link (no backpressure) into a remote receive FIFO
//               of depth CREDITS. A word is only sent while at least one
//               remote slot is known to be free; the receiver returns one
//               credit per popped word.
// Ports       :
//   clk           in   clock, rising edge
//   rst           in   asynchronous active-high reset
//   IN_valid      in   producer has a word
//   IN_data       in   producer word [WIDTH-1:0]
//   OUT_ready     out  sender accepts IN_data this cycle
//   OUT_valid     out  link word valid (registered)
//   OUT_data      out  link word (registered) [WIDTH-1:0]
//   IN_creditRet  in   receiver freed one slot this cycle
//   OUT_credits   out  current credit count [$clog2(CREDITS):0]
//   OUT_idle      out  all credits home
//   OUT_error     out  sticky credit-return overflow flag
// Revision    : 1.0 - initial release
// ============================================================================
module credit_sender #(
    parameter int WIDTH   = 32,
    parameter int CREDITS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       IN_valid,
    input  logic [WIDTH-1:0]           IN_data,
    output logic                       OUT_ready,
    output logic                       OUT_valid,
    output logic [WIDTH-1:0]           OUT_data,
    input  logic                       IN_creditRet,
    output logic [$clog2(CREDITS):0]   OUT_credits,
    output logic                       OUT_idle,
    output logic                       OUT_error
);

    // One extra bit so that CREDITS itself is representable.
    localparam int CNT_W = $clog2(CREDITS) + 1;

    localparam logic [CNT_W-1:0] C_CREDITS_FULL = CNT_W'(CREDITS);
    localparam logic [CNT_W-1:0] C_ONE          = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_ZERO         = '0;

    logic [CNT_W-1:0] r_credits;
    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             r_error;

    logic             w_ready;
    logic             w_send;

    // A credit returned in this same cycle is deliberately not bypassed into
    // ready: it only becomes usable after the edge that counts it. Ready is
    // also forced low while reset is held.
    assign w_ready = (r_credits != C_ZERO) && !rst;
    assign w_send  = IN_valid && w_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_credits <= C_CREDITS_FULL;
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_error   <= 1'b0;
        end else begin
            r_valid <= w_send;
            if (w_send) begin
                r_data <= IN_data;
            end

            // Send and return in the same cycle cancel out.
            case ({w_send, IN_creditRet})
                2'b10: begin
                    r_credits <= r_credits - C_ONE;
                end
                2'b01: begin
                    if (r_credits == C_CREDITS_FULL) begin
                        // Receiver returned a credit it never had: hold the
                        // count at full and flag the violation until reset.
                        r_error <= 1'b1;
                    end else begin
                        r_credits <= r_credits + C_ONE;
                    end
                end
                default: begin
                    r_credits <= r_credits;
                end
            endcase
        end
    end

    assign OUT_ready   = w_ready;
    assign OUT_valid   = r_valid;
    assign OUT_data    = r_data;
    assign OUT_credits = r_credits;
    assign OUT_idle    = (r_credits == C_CREDITS_FULL);
    assign OUT_error   = r_error;

endmodule
`default_nettype wire
